// File: rtl/noc_credit_link_vc.sv
// noc_credit_link_vc: per-VC credit-flow link with pipelined flit and credit-return paths
module noc_credit_link_vc #(
  parameter int FLIT_WIDTH  = 64,
  parameter int NUM_VC      = 2,
  parameter int CREDIT_INIT = 4,
  parameter int LINK_LAT    = 1,
  parameter int CREDIT_LAT  = 1,
  parameter int CNT_W       = 32,
  localparam int CW = $clog2(CREDIT_INIT + 1),
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [FLIT_WIDTH-1:0]  flit_in,
  input  logic [VW-1:0]          vc_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [FLIT_WIDTH-1:0]  flit_out,
  output logic [VW-1:0]          vc_out,
  output logic                   valid_out,
  input  logic [NUM_VC-1:0]      credit_in,
  output logic [NUM_VC*CW-1:0]   credit_level,
  output logic [CNT_W-1:0]       flits_sent_count,
  output logic [CNT_W-1:0]       stall_count,
  output logic                   link_idle,
  output logic                   err_overflow,
  output logic                   err_bad_vc
);
  logic [CW-1:0]         cnt_q [NUM_VC];
  logic [CW-1:0]         cnt_d [NUM_VC];
  logic [LINK_LAT-1:0]   fv_q, fv_d;
  logic [FLIT_WIDTH-1:0] fd_q [LINK_LAT];
  logic [FLIT_WIDTH-1:0] fd_d [LINK_LAT];
  logic [VW-1:0]         fc_q [LINK_LAT];
  logic [VW-1:0]         fc_d [LINK_LAT];
  logic [NUM_VC-1:0]     cp_q [CREDIT_LAT];
  logic [NUM_VC-1:0]     cp_d [CREDIT_LAT];
  logic [CNT_W-1:0]      sent_q, sent_d, stall_q, stall_d;
  logic                  ovf_q, ovf_d, bad_q, bad_d, idle_q, idle_d;
  logic [NUM_VC-1:0]     hit, dec, full, ret;
  logic                  accept, cp_busy;

  always_comb begin
    ready_out = 1'b0;
    hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      hit[v] = vc_in == VW'(v);
      ready_out = ready_out | (hit[v] && cnt_q[v] != '0);
    end
    accept = valid_in && ready_out;
    ret = cp_q[CREDIT_LAT-1];
    fv_d[0] = accept;
    fd_d[0] = accept ? flit_in : '0;
    fc_d[0] = accept ? vc_in : '0;
    for (int s = 1; s < LINK_LAT; s++) begin
      fv_d[s] = fv_q[s-1];
      fd_d[s] = fd_q[s-1];
      fc_d[s] = fc_q[s-1];
    end
    cp_d[0] = credit_in;
    cp_busy = 1'b0;
    for (int s = 1; s < CREDIT_LAT; s++) cp_d[s] = cp_q[s-1];
    for (int s = 0; s < CREDIT_LAT; s++) cp_busy = cp_busy | (|cp_q[s]);
    dec = '0;
    full = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      dec[v] = accept && hit[v];
      full[v] = cnt_q[v] == CW'(CREDIT_INIT);
      // simultaneous take and return cancel out; a return into a full counter is dropped
      cnt_d[v] = (dec[v] && !ret[v]) ? cnt_q[v] - CW'(1) :
                 (ret[v] && !dec[v] && !full[v]) ? cnt_q[v] + CW'(1) : cnt_q[v];
    end
    sent_d = sent_q + CNT_W'(accept);
    stall_d = stall_q + CNT_W'(valid_in && !ready_out);
    ovf_d = ovf_q | (|(ret & ~dec & full));
    bad_d = bad_q | (valid_in && !(|hit));
    idle_d = !(|fv_q) && !cp_busy && (&full);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '{default: CW'(CREDIT_INIT)};
      fv_q    <= '0;
      fd_q    <= '{default: '0};
      fc_q    <= '{default: '0};
      cp_q    <= '{default: '0};
      sent_q  <= '0;
      stall_q <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fd_q    <= fd_d;
      fc_q    <= fc_d;
      cp_q    <= cp_d;
      sent_q  <= sent_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      idle_q  <= idle_d;
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_lvl
    assign credit_level[g*CW +: CW] = cnt_q[g];
  end

  assign valid_out        = fv_q[LINK_LAT-1];
  assign flit_out         = fd_q[LINK_LAT-1];
  assign vc_out           = fc_q[LINK_LAT-1];
  assign flits_sent_count = sent_q;
  assign stall_count      = stall_q;
  assign link_idle        = idle_q;
  assign err_overflow     = ovf_q;
  assign err_bad_vc       = bad_q;
endmodule

// File: tb/tb_noc_credit_link_vc.sv
// tb_noc_credit_link_vc: directed checks of the credit link, default build plus a 3-VC build
module tb_noc_credit_link_vc;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] flit_in, flit_out;
  logic        vc_in, vc_out, valid_in, valid_out, ready_out;
  logic [1:0]  credit_in;
  logic [5:0]  credit_level;
  logic [31:0] flits_sent_count, stall_count;
  logic        link_idle, err_overflow, err_bad_vc;

  logic [7:0]  b_flit_in, b_flit_out;
  logic [1:0]  b_vc_in, b_vc_out;
  logic        b_valid_in, b_valid_out, b_ready_out;
  logic [2:0]  b_credit_in;
  logic [8:0]  b_credit_level;
  logic [31:0] b_sent, b_stall;
  logic        b_idle, b_ovf, b_bad;

  int checks = 0;
  int errors = 0;

  noc_credit_link_vc u_dut (
    .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .vc_in(vc_in), .valid_in(valid_in),
    .ready_out(ready_out), .flit_out(flit_out), .vc_out(vc_out), .valid_out(valid_out),
    .credit_in(credit_in), .credit_level(credit_level), .flits_sent_count(flits_sent_count),
    .stall_count(stall_count), .link_idle(link_idle), .err_overflow(err_overflow),
    .err_bad_vc(err_bad_vc)
  );

  noc_credit_link_vc #(.FLIT_WIDTH(8), .NUM_VC(3)) u_bad (
    .clk(clk), .reset_n(reset_n), .flit_in(b_flit_in), .vc_in(b_vc_in), .valid_in(b_valid_in),
    .ready_out(b_ready_out), .flit_out(b_flit_out), .vc_out(b_vc_out), .valid_out(b_valid_out),
    .credit_in(b_credit_in), .credit_level(b_credit_level), .flits_sent_count(b_sent),
    .stall_count(b_stall), .link_idle(b_idle), .err_overflow(b_ovf), .err_bad_vc(b_bad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int base, min_c;
    reset_n = 1'b0; flit_in = '0; vc_in = 1'b0; valid_in = 1'b0; credit_in = '0;
    b_flit_in = '0; b_vc_in = '0; b_valid_in = 1'b0; b_credit_in = '0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    chk("rst_level", credit_level, 6'o44);
    chk("rst_idle", link_idle, 1);
    chk("rst_vout", valid_out, 0);
    chk("rst_fout", flit_out, 0);
    chk("rst_sent", flits_sent_count, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_err", {err_overflow, err_bad_vc}, 0);
    chk("rst_ready", ready_out, 1);

    b_valid_in = 1'b1; b_vc_in = 2'd3;
    #1;
    chk("bad_ready", b_ready_out, 0);
    tick();
    b_valid_in = 1'b0;
    chk("bad_flag", b_bad, 1);
    chk("bad_vout", b_valid_out, 0);
    chk("bad_stall", b_stall, 1);
    chk("bad_sent", b_sent, 0);
    chk("bad_level", b_credit_level, 9'o444);

    valid_in = 1'b1; vc_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      flit_in = 64'h100 + 64'(k);
      #1;
      chk("s_ready", ready_out, 1);
      tick();
      chk("s_vout", valid_out, 1);
      chk("s_flit", flit_out, 64'h100 + 64'(k));
      chk("s_level", credit_level[2:0], 3'(3 - k));
    end
    chk("s_sent", flits_sent_count, 4);
    chk("s_blocked", ready_out, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("s_stall", stall_count, k);
      chk("s_nov", valid_out, 0);
    end
    vc_in = 1'b1; flit_in = 64'hAA;
    #1;
    chk("vc1_ready", ready_out, 1);
    tick();
    valid_in = 1'b0;
    chk("vc1_vout", {valid_out, vc_out}, 2'b11);
    chk("vc1_flit", flit_out, 64'hAA);
    chk("vc1_level", credit_level, 6'o30);
    chk("vc1_sent", flits_sent_count, 5);
    chk("vc1_stall", stall_count, 3);
    chk("busy_idle", link_idle, 0);

    credit_in = 2'b11;
    tick();
    credit_in = 2'b00;
    chk("cr_lat0", credit_level, 6'o30);
    tick();
    chk("cr_lat1", credit_level, 6'o41);
    credit_in = 2'b01;
    tick(); tick(); tick();
    credit_in = 2'b00;
    tick();
    chk("cr_full", credit_level, 6'o44);
    chk("cr_idle0", link_idle, 0);
    tick();
    chk("cr_idle1", link_idle, 1);

    valid_in = 1'b1; vc_in = 1'b1;
    tick();
    credit_in = 2'b10;
    tick();
    credit_in = 2'b00;
    chk("same_pre", credit_level, 6'o24);
    tick();
    valid_in = 1'b0;
    chk("same_cyc", credit_level, 6'o24);
    chk("same_sent", flits_sent_count, 8);
    credit_in = 2'b10;
    tick(); tick();
    credit_in = 2'b00;
    tick();
    chk("same_back", credit_level, 6'o44);

    base = int'(flits_sent_count);
    min_c = 7;
    valid_in = 1'b1; vc_in = 1'b0;
    for (int k = 0; k < 100; k++) begin
      flit_in = 64'(k);
      credit_in = {valid_out && vc_out, valid_out && !vc_out};
      tick();
      if (k > 5 && int'(credit_level[2:0]) < min_c) min_c = int'(credit_level[2:0]);
    end
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      credit_in = {valid_out && vc_out, valid_out && !vc_out};
      tick();
    end
    credit_in = 2'b00;
    chk("lb_sent", 64'(int'(flits_sent_count) - base >= 95), 1);
    chk("lb_min", 64'(min_c >= 1), 1);
    chk("lb_level", credit_level, 6'o44);
    chk("lb_err", {err_overflow, err_bad_vc}, 0);

    credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    tick();
    chk("ovf_set", err_overflow, 1);
    chk("ovf_level", credit_level, 6'o44);
    tick(); tick();
    chk("ovf_sticky", err_overflow, 1);

    valid_in = 1'b1; vc_in = 1'b0; flit_in = 64'h55;
    tick();
    credit_in = 2'b01;
    tick();
    valid_in = 1'b0; credit_in = 2'b00; reset_n = 1'b0;
    chk("pre_rst_v", valid_out, 1);
    tick();
    reset_n = 1'b1;
    chk("mid_vout", valid_out, 0);
    chk("mid_level", credit_level, 6'o44);
    chk("mid_idle", link_idle, 1);
    chk("mid_err", err_overflow, 0);
    chk("mid_sent", flits_sent_count, 0);
    tick();
    chk("mid_level2", credit_level, 6'o44);
    chk("mid_idle2", link_idle, 1);
    chk("mid_err2", err_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
